// File: rtl/seg7_display_arbiter_pkg.sv
// Shared definitions for the 7-segment display arbiter and its helpers.
package seg7_display_arbiter_pkg;

  localparam int SEG7_VALUE_W   = 8;
  localparam int DEF_HOLD_TICKS = 250;
  localparam int DEF_GAP_TICKS  = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seg7_display_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after start_i, wrapping.
// Purely combinational, no state.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  int               j;
  logic [IDX_W-1:0] jj;

  // Walk the candidates backwards so the nearest one to start_i is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    jj      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j  = (int'(start_i) + k) % N;
      jj = IDX_W'(j);
      if (req_i[jj]) begin
        found_o = 1'b1;
        idx_o   = jj;
      end
    end
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// Shares one 3-digit 7-segment display between NUM_REQ requesters, round-robin,
// with a minimum hold per owner and an optional blank gap; all outputs registered.
module seg7_display_arbiter
  import seg7_display_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int HOLD_TICKS = DEF_HOLD_TICKS,
  parameter  int GAP_TICKS  = DEF_GAP_TICKS,
  localparam int OWN_W      = $clog2(NUM_REQ)
) (
  input  logic                            reset,
  input  logic                            slow_clk,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [SEG7_VALUE_W*NUM_REQ-1:0] value_i,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic [OWN_W-1:0]                owner_o,
  output logic [SEG7_VALUE_W-1:0]         number_out_o,
  output logic                            blank_o
);

  localparam int               CNT_W     = $clog2(max3(HOLD_TICKS, GAP_TICKS, 2));
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam bit               DIRECT    = (GAP_TICKS == 0);

  arb_state_e              state_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OWN_W-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]      grant_q;
  logic [OWN_W-1:0]        owner_q;
  logic [SEG7_VALUE_W-1:0] number_q;
  logic                    blank_q;

  logic                    pick_found;
  logic [OWN_W-1:0]        pick_idx;
  logic                    others_req, owner_req, hold_done, gap_done, do_grant;
  logic [SEG7_VALUE_W-1:0] owner_val, win_val;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (OWN_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .start_i (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    others_req = |(req_i & ~grant_q);
    owner_req  = req_i[owner_q];
    owner_val  = value_i[int'(owner_q)*SEG7_VALUE_W +: SEG7_VALUE_W];
    win_val    = value_i[int'(pick_idx)*SEG7_VALUE_W +: SEG7_VALUE_W];
    hold_done  = (cnt_q == HOLD_LAST);
    gap_done   = (cnt_q == GAP_LAST);
    ptr_d      = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + OWN_W'(1);
    cnt_d      = (state_q == HOLD && hold_done) ? cnt_q : cnt_q + CNT_W'(1);
    // Every path into HOLD (idle start, direct handover, end of gap) shares one grant edge.
    do_grant   = ((state_q == IDLE) && pick_found) ||
                 ((state_q == HOLD) && hold_done && others_req && DIRECT) ||
                 ((state_q == GAP) && gap_done && pick_found);
  end

  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      grant_q  <= '0;
      owner_q  <= '0;
      number_q <= '0;
      blank_q  <= 1'b1;
    end else if (do_grant) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      ptr_q    <= ptr_d;
      grant_q  <= NUM_REQ'(1) << pick_idx;
      owner_q  <= pick_idx;
      number_q <= win_val;
      blank_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        HOLD: begin
          cnt_q <= cnt_d;
          if (owner_req) number_q <= owner_val;
          if (hold_done) begin
            if (others_req) begin
              state_q <= GAP;
              grant_q <= '0;
              blank_q <= 1'b1;
              cnt_q   <= '0;
            end else if (!owner_req) begin
              state_q <= IDLE;
              grant_q <= '0;
              blank_q <= 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_done) state_q <= IDLE;
          else          cnt_q   <= cnt_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o      = grant_q;
  assign owner_o      = owner_q;
  assign number_out_o = number_q;
  assign blank_o      = blank_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with NUM_REQ=4, HOLD_TICKS=4, GAP_TICKS=2.
module tb_seg7_display_arbiter;

  logic        reset;
  logic        slow_clk;
  logic [3:0]  req;
  logic [7:0]  val [4];
  logic [31:0] value;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic [7:0]  number_out;
  logic        blank;

  int n_checks = 0;
  int n_fail   = 0;

  assign value = {val[3], val[2], val[1], val[0]};

  seg7_display_arbiter #(
    .NUM_REQ    (4),
    .HOLD_TICKS (4),
    .GAP_TICKS  (2)
  ) dut (
    .reset        (reset),
    .slow_clk     (slow_clk),
    .req_i        (req),
    .value_i      (value),
    .grant_o      (grant),
    .owner_o      (owner),
    .number_out_o (number_out),
    .blank_o      (blank)
  );

  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0000;
    for (int i = 0; i < 4; i++) val[i] = 8'h00;
    tick();
    tick();
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_checks++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_checks++; if (number_out !== 8'd0) begin n_fail++; $display("FAIL reset_number: got %0d want 0", number_out); end
    n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL reset_blank: got %b want 1", blank); end
    reset = 1'b0;
    tick();
    n_checks++; if (grant !== 4'b0000 || blank !== 1'b1) begin n_fail++; $display("FAIL idle_no_req: grant=%b blank=%b want 0000/1", grant, blank); end
  endtask

  task automatic test_first_grant_and_handover();
    do_reset();
    val[0] = 8'h2A;
    req    = 4'b0001;
    tick();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL first_grant: got %b want 0001", grant); end
    n_checks++; if (number_out !== 8'd42) begin n_fail++; $display("FAIL first_number: got %0d want 42", number_out); end
    n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL first_blank: got %b want 0", blank); end
    n_checks++; if (owner !== 2'd0) begin n_fail++; $display("FAIL first_owner: got %0d want 0", owner); end
    tick();
    val[1] = 8'd7;
    req    = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (grant !== 4'b0001 || blank !== 1'b0) begin n_fail++; $display("FAIL handover_hold%0d: grant=%b blank=%b want 0001/0", i + 2, grant, blank); end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (grant !== 4'b0000 || blank !== 1'b1) begin n_fail++; $display("FAIL handover_gap%0d: grant=%b blank=%b want 0000/1", i, grant, blank); end
    end
    tick();
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL handover_grant: got %b want 0010", grant); end
    n_checks++; if (number_out !== 8'd7) begin n_fail++; $display("FAIL handover_number: got %0d want 7", number_out); end
    n_checks++; if (owner !== 2'd1 || blank !== 1'b0) begin n_fail++; $display("FAIL handover_owner: owner=%0d blank=%b want 1/0", owner, blank); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) val[i] = 8'h10 + 8'(i);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      if (k > 0) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          n_checks++; if (grant !== 4'b0000 || blank !== 1'b1) begin n_fail++; $display("FAIL rotate_gap k=%0d: grant=%b blank=%b want 0000/1", k, grant, blank); end
        end
      end
      for (int h = 0; h < 4; h++) begin
        tick();
        n_checks++; if (grant !== exp_g || blank !== 1'b0) begin n_fail++; $display("FAIL rotate_hold k=%0d h=%0d: grant=%b blank=%b want %b/0", k, h, grant, blank, exp_g); end
        n_checks++; if (number_out !== 8'h10 + 8'(k % 4) || owner !== 2'(k % 4)) begin n_fail++; $display("FAIL rotate_data k=%0d: number=%h owner=%0d want %h/%0d", k, number_out, owner, 8'h10 + 8'(k % 4), k % 4); end
      end
    end
  endtask

  task automatic test_freeze();
    do_reset();
    val[2] = 8'h55;
    req    = 4'b0100;
    tick();
    n_checks++; if (grant !== 4'b0100 || number_out !== 8'h55) begin n_fail++; $display("FAIL freeze_grant: grant=%b number=%h want 0100/55", grant, number_out); end
    tick();
    req    = 4'b0000;
    val[2] = 8'h66;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (number_out !== 8'h55 || grant !== 4'b0100 || blank !== 1'b0) begin n_fail++; $display("FAIL freeze_hold%0d: number=%h grant=%b blank=%b want 55/0100/0", i, number_out, grant, blank); end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (grant !== 4'b0000 || blank !== 1'b1) begin n_fail++; $display("FAIL freeze_idle%0d: grant=%b blank=%b want 0000/1", i, grant, blank); end
      n_checks++; if (number_out !== 8'h55 || owner !== 2'd2) begin n_fail++; $display("FAIL freeze_retain%0d: number=%h owner=%0d want 55/2", i, number_out, owner); end
    end
  endtask

  task automatic test_ramp();
    do_reset();
    val[0] = 8'd0;
    req    = 4'b0001;
    tick();
    for (int i = 0; i < 256; i++) begin
      val[0] = 8'(i);
      tick();
      n_checks++; if (number_out !== 8'(i)) begin n_fail++; $display("FAIL ramp_number i=%0d: got %0d want %0d", i, number_out, i); end
      n_checks++; if (grant !== 4'b0001 || blank !== 1'b0) begin n_fail++; $display("FAIL ramp_grant i=%0d: grant=%b blank=%b want 0001/0", i, grant, blank); end
    end
  endtask

  task automatic test_reset_in_gap();
    do_reset();
    val[0] = 8'h2A;
    val[1] = 8'd7;
    req    = 4'b0001;
    tick();
    req = 4'b0011;
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (grant !== 4'b0000 || blank !== 1'b1) begin n_fail++; $display("FAIL gap_entry: grant=%b blank=%b want 0000/1", grant, blank); end
    reset = 1'b1;
    #1;
    n_checks++; if (grant !== 4'b0000 || number_out !== 8'd0 || blank !== 1'b1) begin n_fail++; $display("FAIL gap_reset: grant=%b number=%0d blank=%b want 0000/0/1", grant, number_out, blank); end
    n_checks++; if (owner !== 2'd0) begin n_fail++; $display("FAIL gap_reset_owner: got %0d want 0", owner); end
    #1;
    reset = 1'b0;
    req   = 4'b1010;
    tick();
    n_checks++; if (grant !== 4'b0010 || number_out !== 8'd7) begin n_fail++; $display("FAIL post_reset_grant: grant=%b number=%0d want 0010/7", grant, number_out); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_grant_and_handover();
    test_rotation();
    test_freeze();
    test_ramp();
    test_reset_in_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_display_arbiter.md
# seg7_display_arbiter

Round-robin arbiter that shares the single 3-digit 7-segment display between up to `NUM_REQ` requesters, such as the CPU output port, the debug bus and the fault/halt code source.
- It runs on the display's multiplex clock `slow_clk`.
- It drives the display's 8-bit number input plus a blank qualifier that gates segments at the top level.
- It enforces a minimum on-screen hold time per owner and an optional blank gap between owners, so values stay readable.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..8.
- `HOLD_TICKS`, 250: minimum `slow_clk` cycles an owner keeps the display; ≥1.
- `GAP_TICKS`, 20: blank cycles inserted between owners; 0 = direct handover.
- `reset` input 1: asynchronous, active-high.
- `slow_clk` input 1: block clock.
- `req` input `NUM_REQ`: request level per requester; held while the requester wants the display.
- `value` input `8*NUM_REQ`: requester i's number on bits `[8i+7:8i]`.
- `grant` output `NUM_REQ`: one-hot owner indication, registered; all-zero when no owner.
- `owner` output `clog2(NUM_REQ)`: index of current or last owner.
- `number_out` output 8: value to display, registered.
- `blank` output 1: 1 = display dark; registered.

## Operation
- States: `IDLE`, `HOLD`, `GAP`.
- Reset state:
  - state = `IDLE`.
  - `grant` = 0.
  - `owner` = 0.
  - `number_out` = 0.
  - `blank` = 1.
  - hold/gap counter = 0.
  - round-robin pointer = 0.
- Pick rule: among asserted `req`, choose the first index searching upward from `(owner+1) mod NUM_REQ`, wrapping. After reset the search starts at index 0, not 1.
- `IDLE`: if any `req`, then `HOLD` with winner. On that edge:
  - `grant` = one-hot(winner).
  - `owner` = winner.
  - `number_out` = winner's value.
  - `blank` = 0.
  - counter = 0.
- `HOLD`: counter increments, saturating at `HOLD_TICKS-1`.
  - `number_out` tracks owner's value every cycle while `req[owner]`=1.
  - `number_out` freezes at its last value once `req[owner]`=0.
  - Leaving `HOLD` is allowed only when the counter has reached `HOLD_TICKS-1` (hold expired).
- After hold expiry, evaluated each cycle:
  - If any other `req` is asserted: go to `GAP` if `GAP_TICKS`>0, with `grant`=0, `blank`=1, counter=0. If `GAP_TICKS`=0, hand over directly to the new winner, with identical effects to the IDLE→HOLD edge.
  - Else if `req[owner]`=1: stay in `HOLD`; the owner keeps the display indefinitely.
  - Else: go to `IDLE` with `grant`=0, `blank`=1; `number_out` and `owner` retain their values.
- `GAP`:
  - Counts to `GAP_TICKS-1`.
  - Then picks the winner using `req` sampled on that cycle and enters `HOLD`.
  - If no `req` is asserted at that point, goes to `IDLE`.
  - The previous owner is eligible only if no one else requests; this follows from the pick rule.
- `owner` updates only on a grant edge.
- `value` of non-owners is ignored.
- Widths:
  - Counter width is `clog2(max(HOLD_TICKS, GAP_TICKS, 2))`.
  - Values are unsigned 8-bit; no arithmetic on data.

## Timing
- All outputs are registered on `slow_clk` posedge; no combinational input→output paths.
- Request-to-grant latency:
  - From `IDLE`: 1 cycle (req high before edge n gives `grant` at edge n).
  - Owner-to-owner handover: `HOLD_TICKS` minimum on-screen cycles, plus `GAP_TICKS` blank cycles, plus 0 extra.
- Value tracking latency while owned: 1 cycle.
- Simultaneous requests: resolved solely by the round-robin pointer; no fixed priority.
- A requester dropping and re-raising `req` during another owner's hold is served in rotation order, with no queue memory beyond the current `req` level.
- `reset` asserted mid-operation returns immediately (asynchronously) to the reset values above. The first grant after release uses search start 0.
- Reconfiguration is not supported: parameters are static.

## Structure
- Shared display package holds:
  - state enum (`IDLE`, `HOLD`, `GAP`).
  - `SEG7_VALUE_W` = 8.
  - default `HOLD_TICKS`/`GAP_TICKS` constants.
- One combinational sub-module, `rr_pick`: inputs `req` and start index; outputs `found` and index. It is reusable by other arbiters.
- The FSM, counter and output registers live in `seg7_display_arbiter`.

## Test plan
All scenarios use `NUM_REQ`=4, `HOLD_TICKS`=4, `GAP_TICKS`=2.
- Reset, then `req`=0001, `value0`=0x2A → `grant`=0001 and `number_out`=42 one edge after req; `blank`=0; `owner`=0.
- Owner 0 holding; raise `req1` (`value1`=7) at hold cycle 1 → `grant0` held exactly 4 cycles; then 2 cycles `blank`=1, `grant`=0; then `grant`=0010, `number_out`=7.
- `req`=1111 continuously → grants rotate 0,1,2,3,0, each 4 on-cycles separated by 2 blank cycles.
- Owner 2 drops `req` at hold cycle 1 while `value2` changes → `number_out` frozen; after hold expiry `IDLE`, `blank`=1, `number_out` retains value, `owner`=2.
- Single owner with `value` ramping 0..255 → `number_out` follows with 1-cycle lag; no blanking; `grant` stays one-hot.
- Assert `reset` during `GAP` → outputs immediately `grant`=0, `number_out`=0, `blank`=1; after release, `req`=1010 → `grant`=0010.
